// File: rtl/ocx_tlx_fifo_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ocx_tlx_fifo_gen : first-word-fall-through FIFO, selectable depth     |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module ocx_tlx_fifo_gen #(
   parameter int WIDTH        = 514,
   parameter int ADDR_WIDTH   = 5,
   parameter int MIN_DEPTH    = 16,
   parameter int AFULL_MARGIN = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [WIDTH-1:0]      data_in,
   input  logic                  wr_enable,
   input  logic                  rd_done,
   input  logic                  use_min_fifo_depth,
   input  logic                  error_clear,
   output logic [WIDTH-1:0]      data_out,
   output logic                  data_available,
   output logic                  data_look_ahead,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  almost_full,
   output logic                  overflow_error,
   output logic                  underflow_error
);

   localparam logic [ADDR_WIDTH:0] c_phys_depth = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] c_min_depth  = (ADDR_WIDTH+1)'(MIN_DEPTH);
   localparam logic [ADDR_WIDTH:0] c_margin     = (ADDR_WIDTH+1)'(AFULL_MARGIN);

   logic [WIDTH-1:0]      r_mem [2**ADDR_WIDTH];
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH-1:0] w_rd_ptr_nxt;
   logic [ADDR_WIDTH:0]   w_depth;
   logic [ADDR_WIDTH:0]   w_count_nxt;
   logic [WIDTH-1:0]      w_head_nxt;
   logic                  w_wr_acc;
   logic                  w_pop;
   logic                  w_load_head;

   assign w_depth         = use_min_fifo_depth ? c_min_depth : c_phys_depth;
   assign full            = (count >= w_depth);
   assign almost_full     = (count >= (w_depth - c_margin));
   assign data_available  = (count != '0);
   assign data_look_ahead = |count[ADDR_WIDTH:1];

   assign w_wr_acc     = wr_enable & ~full;
   assign w_pop        = rd_done & data_available;
   assign w_rd_ptr_nxt = w_pop ? (r_rd_ptr + ADDR_WIDTH'(1)) : r_rd_ptr;

   always_comb begin
      w_count_nxt = count;
      case ({w_wr_acc, w_pop})
         2'b10:   w_count_nxt = count + (ADDR_WIDTH+1)'(1);
         2'b01:   w_count_nxt = count - (ADDR_WIDTH+1)'(1);
         default: w_count_nxt = count;
      endcase
   end

   // The head register reloads on a pop or on a write into an empty FIFO; the
   // entry being written this cycle is bypassed since the array is not yet updated.
   assign w_load_head = w_pop | (w_wr_acc & ~data_available);
   assign w_head_nxt  = (w_wr_acc && (r_wr_ptr == w_rd_ptr_nxt)) ? data_in
                                                                 : r_mem[w_rd_ptr_nxt];

   always_ff @(posedge clock) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr        <= '0;
         r_rd_ptr        <= '0;
         count           <= '0;
         data_out        <= '0;
         overflow_error  <= 1'b0;
         underflow_error <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
         end
         r_rd_ptr <= w_rd_ptr_nxt;
         count    <= w_count_nxt;
         if (w_load_head && (w_count_nxt != '0)) begin
            data_out <= w_head_nxt;
         end
         // A fresh error wins over a simultaneous clear.
         overflow_error  <= (overflow_error  & ~error_clear) | (wr_enable & full);
         underflow_error <= (underflow_error & ~error_clear) | (rd_done & ~data_available);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ocx_tlx_fifo_gen.sv
`default_nettype none
// Directed self-checking bench for ocx_tlx_fifo_gen (default parameters).
module tb_ocx_tlx_fifo_gen;

   localparam int WIDTH = 514;
   localparam int AW    = 5;

   logic             clock;
   logic             reset;
   logic [WIDTH-1:0] data_in;
   logic             wr_enable;
   logic             rd_done;
   logic             use_min_fifo_depth;
   logic             error_clear;
   logic [WIDTH-1:0] data_out;
   logic             data_available;
   logic             data_look_ahead;
   logic [AW:0]      count;
   logic             full;
   logic             almost_full;
   logic             overflow_error;
   logic             underflow_error;

   int vectors    = 0;
   int miscompares = 0;

   ocx_tlx_fifo_gen dut (
      .clock              (clock),
      .reset              (reset),
      .data_in            (data_in),
      .wr_enable          (wr_enable),
      .rd_done            (rd_done),
      .use_min_fifo_depth (use_min_fifo_depth),
      .error_clear        (error_clear),
      .data_out           (data_out),
      .data_available     (data_available),
      .data_look_ahead    (data_look_ahead),
      .count              (count),
      .full               (full),
      .almost_full        (almost_full),
      .overflow_error     (overflow_error),
      .underflow_error    (underflow_error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_d(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_n(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk_d({tag, "_dout"}, data_out, '0);
      chk_n({tag, "_avail"}, int'(data_available), 0);
      chk_n({tag, "_look"}, int'(data_look_ahead), 0);
      chk_n({tag, "_count"}, int'(count), 0);
      chk_n({tag, "_full"}, int'(full), 0);
      chk_n({tag, "_afull"}, int'(almost_full), 0);
      chk_n({tag, "_ovf"}, int'(overflow_error), 0);
      chk_n({tag, "_udf"}, int'(underflow_error), 0);
   endtask

   task automatic write1(input logic [WIDTH-1:0] d);
      data_in   = d;
      wr_enable = 1'b1;
      tick();
      wr_enable = 1'b0;
   endtask

   task automatic pop1();
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
   endtask

   initial begin
      logic [WIDTH-1:0] wide;
      reset = 1'b1; data_in = '0; wr_enable = 1'b0; rd_done = 1'b0;
      use_min_fifo_depth = 1'b0; error_clear = 1'b0;
      // inputs active during reset must be ignored
      wr_enable = 1'b1; rd_done = 1'b1; data_in = WIDTH'(32'h55);
      tick(); tick();
      chk_all_zero("reset");
      wr_enable = 1'b0; rd_done = 1'b0;
      reset = 1'b0;
      tick();

      // first write into empty FIFO
      write1(WIDTH'(1));
      chk_n("w1_avail", int'(data_available), 1);
      chk_d("w1_dout", data_out, WIDTH'(1));
      chk_n("w1_count", int'(count), 1);
      chk_n("w1_look", int'(data_look_ahead), 0);
      pop1();
      chk_n("p1_count", int'(count), 0);
      chk_n("p1_avail", int'(data_available), 0);
      chk_d("p1_hold", data_out, WIDTH'(1));

      // full-depth fill with pointer wrap; entry 0 carries a wide pattern
      wide = '0;
      wide[WIDTH-1] = 1'b1;
      wide[300]     = 1'b1;
      for (int i = 0; i < 32; i++) begin
         write1((i == 0) ? (wide | WIDTH'(32'h100)) : WIDTH'(32'h100 + i));
         chk_n("fill_count", int'(count), i + 1);
         chk_n("fill_afull", int'(almost_full), (i + 1 >= 28) ? 1 : 0);
         chk_n("fill_full", int'(full), (i + 1 >= 32) ? 1 : 0);
      end
      write1(WIDTH'(32'hDEAD));
      chk_n("ovf_flag", int'(overflow_error), 1);
      chk_n("ovf_count", int'(count), 32);
      for (int i = 0; i < 32; i++) begin
         chk_d("drain_dout", data_out, (i == 0) ? (wide | WIDTH'(32'h100)) : WIDTH'(32'h100 + i));
         chk_n("drain_look", int'(data_look_ahead), (i < 31) ? 1 : 0);
         pop1();
      end
      chk_n("drain_count", int'(count), 0);
      chk_n("drain_avail", int'(data_available), 0);
      error_clear = 1'b1;
      tick();
      error_clear = 1'b0;
      chk_n("ovf_clear", int'(overflow_error), 0);

      // reduced depth
      use_min_fifo_depth = 1'b1;
      for (int i = 0; i < 16; i++) begin
         write1(WIDTH'(32'h200 + i));
         chk_n("min_afull", int'(almost_full), (i + 1 >= 12) ? 1 : 0);
         chk_n("min_full", int'(full), (i + 1 >= 16) ? 1 : 0);
      end
      write1(WIDTH'(32'h2EE));
      chk_n("min_ovf", int'(overflow_error), 1);
      chk_n("min_ovf_count", int'(count), 16);
      use_min_fifo_depth = 1'b0;
      #1;
      chk_n("max_full", int'(full), 0);
      chk_n("max_afull", int'(almost_full), 0);
      write1(WIDTH'(32'h2FF));
      chk_n("w17_count", int'(count), 17);
      error_clear = 1'b1;
      tick();
      error_clear = 1'b0;
      chk_n("ovf_clear2", int'(overflow_error), 0);
      use_min_fifo_depth = 1'b1;
      #1;
      chk_n("shrink_full", int'(full), 1);
      chk_d("shrink_d0", data_out, WIDTH'(32'h200));
      pop1();
      chk_n("shrink_full16", int'(full), 1);
      chk_d("shrink_d1", data_out, WIDTH'(32'h201));
      pop1();
      chk_n("shrink_full15", int'(full), 0);
      for (int i = 0; i < 15; i++) begin
         chk_d("shrink_drain", data_out, (i < 14) ? WIDTH'(32'h202 + i) : WIDTH'(32'h2FF));
         pop1();
      end
      chk_n("shrink_empty", int'(count), 0);
      use_min_fifo_depth = 1'b0;

      // simultaneous write and pop at count 1
      write1(WIDTH'(32'h5));
      data_in = WIDTH'(32'hA); wr_enable = 1'b1; rd_done = 1'b1;
      tick();
      wr_enable = 1'b0; rd_done = 1'b0;
      chk_d("wp_dout", data_out, WIDTH'(32'hA));
      chk_n("wp_count", int'(count), 1);
      chk_n("wp_avail", int'(data_available), 1);
      pop1();
      chk_n("wp_empty", int'(count), 0);

      // underflow and clear priority
      pop1();
      chk_n("udf_flag", int'(underflow_error), 1);
      chk_n("udf_count", int'(count), 0);
      error_clear = 1'b1;
      tick();
      chk_n("udf_clear", int'(underflow_error), 0);
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0; error_clear = 1'b0;
      chk_n("udf_sticky", int'(underflow_error), 1);

      // asynchronous reset mid-stream
      for (int i = 0; i < 7; i++) write1(WIDTH'(32'h300 + i));
      chk_n("pre_rst_count", int'(count), 7);
      reset = 1'b1;
      #1;
      chk_all_zero("async_rst");
      tick();
      reset = 1'b0;
      write1(WIDTH'(32'h77));
      chk_n("post_rst_count", int'(count), 1);
      chk_d("post_rst_dout", data_out, WIDTH'(32'h77));
      chk_n("post_rst_look", int'(data_look_ahead), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ocx_tlx_fifo_gen.md
OCX_TLX_FIFO_GEN -- requirements
Module: ocx_tlx_fifo_gen

Interface
REQ-001 Parameter WIDTH, default 514, data word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 5, physical depth = 2^ADDR_WIDTH entries (32).
REQ-003 Parameter MIN_DEPTH, default 16, effective depth when use_min_fifo_depth=1; legal range 2..2^ADDR_WIDTH.
REQ-004 Parameter AFULL_MARGIN, default 4, free entries remaining at which almost_full asserts; legal range 0..MIN_DEPTH-1.
REQ-005 Ports: one clock; reset is asynchronous and active-high.
REQ-006 clock  input  1  single rising-edge clock for all state.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 data_in  input  WIDTH  write data.
REQ-009 wr_enable  input  1  write request, one entry per cycle.
REQ-010 rd_done  input  1  pop head entry currently on data_out.
REQ-011 use_min_fifo_depth  input  1  select effective depth MIN_DEPTH (1) or 2^ADDR_WIDTH (0).
REQ-012 error_clear  input  1  clear sticky error flags.
REQ-013 data_out  output  WIDTH  head entry, registered, first-word-fall-through.
REQ-014 data_available  output  1  data_out holds a valid head entry.
REQ-015 data_look_ahead  output  1  at least one entry behind the head.
REQ-016 count  output  ADDR_WIDTH+1  registered occupancy including head.
REQ-017 full  output  1  count >= effective depth.
REQ-018 almost_full  output  1  count >= effective depth - AFULL_MARGIN.
REQ-019 overflow_error / underflow_error  output  1 each  sticky error flags.

Function
REQ-020 Effective depth D SHALL be MIN_DEPTH when use_min_fifo_depth=1, else 2^ADDR_WIDTH; evaluated combinationally each cycle.
REQ-021 Read/write pointers SHALL always wrap modulo 2^ADDR_WIDTH regardless of D; D affects only full/almost_full.
REQ-022 A write SHALL be accepted when wr_enable=1 and full=0; data_in stored at write pointer, pointer +1.
REQ-023 wr_enable=1 with full=1 SHALL drop the write, leave all state unchanged, and set overflow_error, even if rd_done=1 same cycle (the pop still occurs).
REQ-024 A pop SHALL occur when rd_done=1 and data_available=1; next entry (if any) appears on data_out the following cycle.
REQ-025 rd_done=1 with data_available=0 SHALL be ignored and set underflow_error.
REQ-026 Write-to-data_available latency into an empty FIFO SHALL be exactly 1 cycle; data_out valid same cycle as data_available.
REQ-027 Simultaneous accepted write and pop SHALL leave count unchanged; at count=1 the new entry SHALL be on data_out next cycle with data_available held at 1.
REQ-028 count SHALL update next cycle: +1 write only, -1 pop only, unchanged for both or neither; never exceeds 2^ADDR_WIDTH.
REQ-029 data_available SHALL equal (count>=1); data_look_ahead SHALL equal (count>=2); full and almost_full derived from registered count and current D.
REQ-030 Switching use_min_fifo_depth to 1 while count>MIN_DEPTH SHALL lose no data; full stays 1 until count drains below MIN_DEPTH.
REQ-031 Error flags SHALL remain set until error_clear=1; a new error in the same cycle as error_clear SHALL leave the flag set.
REQ-032 data_out SHALL hold its last value when data_available=0.

Reset
REQ-033 reset=1 SHALL asynchronously force pointers, count, data_out, data_available, data_look_ahead, full, almost_full, overflow_error, underflow_error to 0.
REQ-034 Storage array contents SHALL not require reset; reset mid-operation discards all entries and first post-reset write behaves as into empty FIFO.
REQ-035 All inputs SHALL be ignored while reset=1.

Verification
REQ-036 Defaults, empty: write 0x1 at cycle 0 -> cycle 1 data_available=1, data_out=0x1, count=1, data_look_ahead=0.
REQ-037 Fill 32 writes, use_min_fifo_depth=0 -> almost_full at count=28, full at 32; 33rd write -> overflow_error=1, count=32, pop order 0..31 intact across pointer wrap.
REQ-038 use_min_fifo_depth=1: 16 writes -> full=1, almost_full at count=12; set to 0 -> full=0, 17th write accepted.
REQ-039 count=1, wr_enable+rd_done same cycle with data_in=0xA -> next cycle data_out=0xA, count=1, data_available=1 continuously.
REQ-040 rd_done on empty -> underflow_error=1, count=0; error_clear -> 0 next cycle; error_clear plus rd_done on empty -> flag stays 1.
REQ-041 reset asserted mid-stream at count=7 -> all outputs 0 immediately, before next clock edge; next write yields count=1 with new data.
